// File: rtl/vco_freq_meter.sv
// Gated edge counter measuring the VCO output frequency over GATE_CYCLES clocks.
// Optional macro FREQ_METER_DUAL_EDGE_EN counts both edges of the synchronized input.
module vco_freq_meter #(
  parameter int unsigned GATE_CYCLES = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_sig,
  output logic [7:0] o_data,
  output logic       o_sat,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_overrun
);
  localparam int unsigned GATE_W = 16;
  localparam int unsigned CNT_W  = 9;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             data_q, data_d;
  logic                   sat_q, sat_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic                   edge_c;
  logic                   accept_c;
  logic                   last_c;
  logic                   commit_c;
  logic [CNT_W-1:0]       cnt_inc_c;

  // Synchronizer and edge-detect flop run in every state so prev_q tracks sync_q.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_sig};
  assign prev_d = sync_q[SYNC_STAGES-1];

`ifdef FREQ_METER_DUAL_EDGE_EN
  assign edge_c = sync_q[SYNC_STAGES-1] ^ prev_q;
`else
  assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;
`endif

  // Counter holds once bit 8 sets; that window reports 255 with o_sat.
  assign cnt_inc_c = (edge_c && !cnt_q[CNT_W-1]) ? cnt_q + CNT_W'(1) : cnt_q;
  assign accept_c  = valid_q & i_ready;
  assign last_c    = (state_q == MEASURE) && (gate_q == GATE_LAST);
  assign commit_c  = last_c && (!valid_q || accept_c);

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    sat_d     = sat_q;
    valid_d   = valid_q & ~accept_c;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = MEASURE;
          gate_d  = '0;
          cnt_d   = '0;
        end
      end
      MEASURE: begin
        if (last_c) begin
          if (commit_c) begin
            data_d  = cnt_inc_c[CNT_W-1] ? 8'hFF : cnt_inc_c[7:0];
            sat_d   = cnt_inc_c[CNT_W-1];
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          gate_d  = '0;
          cnt_d   = '0;
          state_d = i_enable ? MEASURE : IDLE;
        end else if (!i_enable) begin
          state_d = IDLE;
        end else begin
          gate_d = gate_q + GATE_W'(1);
          cnt_d  = cnt_inc_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      gate_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data    = data_q;
  assign o_sat     = sat_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;
  assign o_busy    = (state_q == MEASURE);

endmodule

// File: tb/tb_vco_freq_meter.sv
// Testbench for vco_freq_meter: two instances (short and long gate) sharing inputs.
module tb_vco_freq_meter;
  localparam int unsigned G_A    = 64;
  localparam int unsigned G_B    = 1024;
  localparam int          SYNC_A = 2;
  localparam int          N_RAND = 800;
  localparam int          N_VEC  = 8;
`ifdef FREQ_METER_DUAL_EDGE_EN
  localparam int EDGE_MULT = 2;
`else
  localparam int EDGE_MULT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, en, sig, rdy;
  logic [7:0] a_data, b_data;
  logic       a_sat, a_valid, a_busy, a_ovr;
  logic       b_sat, b_valid, b_busy, b_ovr;

  int n_checks = 0;
  int n_fail   = 0;
  int gen_period = 0;
  int gen_ph     = 0;

  typedef struct {
    bit use_b;
    int period;
    int exp_data;
    int exp_sat;
  } vec_t;
  vec_t vecs[N_VEC];

  vco_freq_meter #(.GATE_CYCLES(G_A), .SYNC_STAGES(SYNC_A)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_sig(sig),
    .o_data(a_data), .o_sat(a_sat), .o_valid(a_valid), .i_ready(rdy),
    .o_busy(a_busy), .o_overrun(a_ovr)
  );

  vco_freq_meter #(.GATE_CYCLES(G_B), .SYNC_STAGES(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_sig(sig),
    .o_data(b_data), .o_sat(b_sat), .o_valid(b_valid), .i_ready(rdy),
    .o_busy(b_busy), .o_overrun(b_ovr)
  );

  initial forever #5 clk = ~clk;

  // Square-wave source for i_sig, changed just after each rising clock edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (gen_period != 0) begin
      gen_ph = (gen_ph + 1) % gen_period;
      sig    = (gen_ph < gen_period / 2);
    end
  end

  // {busy, overrun, valid, sat, data[7:0]}
  function automatic logic [11:0] outs(input bit b);
    return b ? {b_busy, b_ovr, b_valid, b_sat, b_data}
             : {a_busy, a_ovr, a_valid, a_sat, a_data};
  endfunction

  function automatic vec_t mk(input bit b, input int period, input int base);
    vec_t v;
    int   n;
    n = base * EDGE_MULT;
    v.use_b    = b;
    v.period   = period;
    v.exp_data = (n > 255) ? 255 : n;
    v.exp_sat  = (n > 255) ? 1 : 0;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input bit b, input int v, input int d,
                           input int s, input int ov, input int bz);
    logic [11:0] o;
    o = outs(b);
    check({name, "_valid"},   int'(o[9]),   v);
    check({name, "_data"},    int'(o[7:0]), d);
    check({name, "_sat"},     int'(o[8]),   s);
    check({name, "_overrun"}, int'(o[10]),  ov);
    check({name, "_busy"},    int'(o[11]),  bz);
  endtask

  // Wait (at negedges) for o_valid to reach lvl; an expired budget shows up as a failed check.
  task automatic wait_valid(input bit b, input logic lvl, input int budget, input string name);
    int          n;
    logic [11:0] o;
    n = 0;
    o = outs(b);
    while (o[9] !== lvl && n < budget) begin
      @(negedge clk);
      n++;
      o = outs(b);
    end
    check({name, "_wait"}, int'(o[9]), int'(lvl));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_gen(input int period);
    gen_ph     = 0;
    gen_period = period;
  endtask

  // Random-phase model state
  bit sh[N_RAND];
  bit rh[N_RAND];

  function automatic int edge_at(input int k);
    int s1, s0;
    s1 = (k - SYNC_A >= 0)     ? int'(sh[k - SYNC_A])     : 0;
    s0 = (k - SYNC_A - 1 >= 0) ? int'(sh[k - SYNC_A - 1]) : 0;
`ifdef FREQ_METER_DUAL_EDGE_EN
    return (s1 != s0) ? 1 : 0;
`else
    return (s1 == 1 && s0 == 0) ? 1 : 0;
`endif
  endfunction

  initial begin
    logic [11:0] o;
    int          first_data;
    int          cnt, md, ms, mv, mo;
    bit          acc, win_end, commit;

    sig = 1'b0;
    rst = 1'b1;
    en  = 1'b0;
    rdy = 1'b0;

    vecs[0] = mk(1'b0, 8,  G_A / 8);
    vecs[1] = mk(1'b0, 16, G_A / 16);
    vecs[2] = mk(1'b0, 4,  G_A / 4);
    vecs[3] = mk(1'b0, 2,  G_A / 2);
    vecs[4] = mk(1'b0, 64, G_A / 64);
    vecs[5] = mk(1'b1, 2,  G_B / 2);
    vecs[6] = mk(1'b1, 4,  G_B / 4);
    vecs[7] = mk(1'b1, 8,  G_B / 8);

    do_reset();
    @(negedge clk);
    check_all("reset_a", 1'b0, 0, 0, 0, 0, 0);
    check_all("reset_b", 1'b1, 0, 0, 0, 0, 0);

    // Periodic input: each window holds exactly G/P periods, back-to-back windows too
    for (int i = 0; i < N_VEC; i++) begin
      start_gen(vecs[i].period);
      do_reset();
      repeat (2 * vecs[i].period + 4) @(negedge clk);
      rdy = 1'b1;
      en  = 1'b1;
      wait_valid(vecs[i].use_b, 1'b1, 2 * (vecs[i].use_b ? G_B : G_A) + 50, $sformatf("vec%0d_first", i));
      o = outs(vecs[i].use_b);
      check($sformatf("vec%0d_first_data", i), int'(o[7:0]), vecs[i].exp_data);
      check($sformatf("vec%0d_first_sat", i),  int'(o[8]),   vecs[i].exp_sat);
      wait_valid(vecs[i].use_b, 1'b0, 4, $sformatf("vec%0d_drop", i));
      wait_valid(vecs[i].use_b, 1'b1, 2 * (vecs[i].use_b ? G_B : G_A) + 50, $sformatf("vec%0d_second", i));
      o = outs(vecs[i].use_b);
      check($sformatf("vec%0d_second_data", i), int'(o[7:0]), vecs[i].exp_data);
      check($sformatf("vec%0d_second_sat", i),  int'(o[8]),   vecs[i].exp_sat);
    end

    // Overrun: consumer stalls across two windows, result retained, then drained
    start_gen(8);
    do_reset();
    repeat (20) @(negedge clk);
    rdy = 1'b0;
    en  = 1'b1;
    wait_valid(1'b0, 1'b1, 2 * G_A + 50, "ovr_first");
    first_data = int'(a_data);
    check("ovr_first_data", first_data, (G_A / 8) * EDGE_MULT);
    repeat (2 * G_A + 10) @(negedge clk);
    check_all("ovr_stall", 1'b0, 1, (G_A / 8) * EDGE_MULT, 0, 1, 1);
    rdy = 1'b1;
    @(negedge clk);
    check("ovr_accept_valid", int'(a_valid), 0);
    wait_valid(1'b0, 1'b1, 2 * G_A + 50, "ovr_next");
    check("ovr_next_data", int'(a_data), (G_A / 8) * EDGE_MULT);
    check("ovr_sticky", int'(a_ovr), 1);

    // Reset mid-window with a pending result and overrun set
    rdy = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_pre_valid", int'(a_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    check_all("rstmid", 1'b0, 0, 0, 0, 0, 0);

    // Abort at gate=100 on the long-gate instance, then a fresh full window
    start_gen(16);
    do_reset();
    repeat (40) @(negedge clk);
    rdy = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #1;
    en = 1'b0;
    check("abort_pre_busy", int'(b_busy), 1);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", int'(b_busy), 0);
    check("abort_valid", int'(b_valid), 0);
    repeat (5) @(negedge clk);
    check("abort_idle_busy", int'(b_busy), 0);
    en = 1'b1;
    wait_valid(1'b1, 1'b1, G_B + 50, "abort_fresh");
    check("abort_fresh_data", int'(b_data), (G_B / 16) * EDGE_MULT);
    check("abort_fresh_sat", int'(b_sat), 0);

    // Random i_sig and i_ready against a window-level model of the short-gate instance
    start_gen(0);
    sig = 1'b0;
    do_reset();
    cnt = 0; md = 0; ms = 0; mv = 0; mo = 0;
    for (int k = 0; k < N_RAND; k++) begin
      sig   = 1'($urandom_range(0, 1));
      rdy   = ($urandom_range(0, 3) == 0);
      en    = 1'b1;
      sh[k] = sig;
      rh[k] = rdy;
      @(posedge clk);
      acc     = (mv == 1) && rh[k];
      win_end = (k >= 1) && (k % G_A == 0);
      commit  = win_end && (mv == 0 || acc);
      if (k >= 1) cnt = (cnt + edge_at(k) > 256) ? 256 : cnt + edge_at(k);
      if (commit) begin
        mv = 1;
        md = (cnt > 255) ? 255 : cnt;
        ms = (cnt > 255) ? 1 : 0;
      end else if (acc) begin
        mv = 0;
      end
      if (win_end && !commit) mo = 1;
      if (win_end) cnt = 0;
      @(negedge clk);
      check_all($sformatf("rand%0d", k), 1'b0, mv, md, ms, mo, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
